// File: rtl/unidad_riesgos_pipeline_pkg.sv
// Shared definitions for the pipeline hazard unit.
//   - Forwarding-select codes driven onto the E-stage operand muxes.
//   - Two-state controller encoding (normal flow / waiting on multi-cycle unit).
package unidad_riesgos_pipeline_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = 2'b00;  // operand from register file
  localparam fwd_sel_t FWD_W  = 2'b01;  // operand bypassed from W
  localparam fwd_sel_t FWD_M  = 2'b10;  // operand bypassed from M

  typedef logic [0:0] state_t;

  localparam state_t RUN     = 1'b0;
  localparam state_t MC_WAIT = 1'b1;

endpackage

// File: rtl/unidad_riesgos_pipeline_if.sv
// Signal bundle between the pipeline datapath and the hazard unit.
//   master : datapath side, drives register addresses and stage status,
//            receives enables, clears, forwarding selects and mc_start.
//   slave  : hazard unit side.
interface unidad_riesgos_pipeline_if #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] rs1_d, rs2_d;
  logic [REG_ADDR_W-1:0] rs1_e, rs2_e;
  logic [REG_ADDR_W-1:0] rd_e, rd_m, rd_w;
  logic                  reg_write_m, reg_write_w;
  logic                  mem_to_reg_e;
  logic                  branch_taken_e;
  logic                  mc_op_e;
  logic                  mc_done;
  logic                  mc_start;
  logic                  en_f, en_d, en_e, en_m;
  logic                  clear_d, clear_e, clear_m;
  logic [1:0]            fwd_a_e, fwd_b_e;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output reg_write_m, reg_write_w, mem_to_reg_e, branch_taken_e, mc_op_e, mc_done,
    input  mc_start, en_f, en_d, en_e, en_m, clear_d, clear_e, clear_m,
    input  fwd_a_e, fwd_b_e, stall_count
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  reg_write_m, reg_write_w, mem_to_reg_e, branch_taken_e, mc_op_e, mc_done,
    output mc_start, en_f, en_d, en_e, en_m, clear_d, clear_e, clear_m,
    output fwd_a_e, fwd_b_e, stall_count
  );

endinterface

// File: rtl/unidad_riesgos_pipeline_selector_adelanto.sv
// Per-operand forwarding select for the E stage (purely combinational).
//   rs_e                     : source register of the operand in E
//   rd_m, reg_write_m        : producer in M (highest priority, youngest value)
//   rd_w, reg_write_w        : producer in W
//   sel                      : FWD_M / FWD_W / FWD_RF
module selector_adelanto
  import unidad_riesgos_pipeline_pkg::*;
#(
  parameter int REG_ADDR_W  = 4,
  parameter bit ZERO_REG_EN = 1'b0
) (
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_m,
  input  logic                  reg_write_w,
  output fwd_sel_t              sel
);

  always_comb begin
    sel = FWD_RF;
    if (ZERO_REG_EN && (rs_e == '0)) begin
      // Hard-wired zero register: never bypass a stale write to it.
      sel = FWD_RF;
    end else if (reg_write_m && (rd_m == rs_e)) begin
      sel = FWD_M;
    end else if (reg_write_w && (rd_w == rs_e)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/unidad_riesgos_pipeline.sv
// Hazard and stall controller for the 5-stage pipeline (F, D, E, M, W).
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of unidad_riesgos_pipeline_if
//     in  : rs1/rs2 of D and E, rd of E/M/W, reg_write_m/w, mem_to_reg_e,
//           branch_taken_e, mc_op_e, mc_done
//     out : en_f/d/e/m, clear_d/e/m, fwd_a_e/fwd_b_e, mc_start, stall_count
// Priority in RUN: multi-cycle op > taken branch flush > load-use stall.
// Every clear is issued together with the matching enable, since the stage
// registers only honour clear while enabled.
module unidad_riesgos_pipeline
  import unidad_riesgos_pipeline_pkg::*;
#(
  parameter int REG_ADDR_W  = 4,
  parameter int CNT_W       = 16,
  parameter bit ZERO_REG_EN = 1'b0
) (
  input logic                      clk,
  input logic                      reset,
  unidad_riesgos_pipeline_if.slave bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_count_q;
  fwd_sel_t         fwd_a, fwd_b;
  logic             load_use;
  logic             mc_start, en_f, en_d, en_e, en_m, clear_d, clear_e, clear_m;

  selector_adelanto #(
    .REG_ADDR_W  (REG_ADDR_W),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_sel_a (
    .rs_e        (bus.rs1_e),
    .rd_m        (bus.rd_m),
    .rd_w        (bus.rd_w),
    .reg_write_m (bus.reg_write_m),
    .reg_write_w (bus.reg_write_w),
    .sel         (fwd_a)
  );

  selector_adelanto #(
    .REG_ADDR_W  (REG_ADDR_W),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_sel_b (
    .rs_e        (bus.rs2_e),
    .rd_m        (bus.rd_m),
    .rd_w        (bus.rd_w),
    .reg_write_m (bus.reg_write_m),
    .reg_write_w (bus.reg_write_w),
    .sel         (fwd_b)
  );

  // Load in E feeding the instruction in D: its value is not ready in time
  // for forwarding, so D must wait one cycle.
  assign load_use = bus.mem_to_reg_e &&
                    ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d)) &&
                    !(ZERO_REG_EN && (bus.rd_e == '0));

  always_comb begin
    state_d  = state_q;
    mc_start = 1'b0;
    en_f     = 1'b1;
    en_d     = 1'b1;
    en_e     = 1'b1;
    en_m     = 1'b1;
    clear_d  = 1'b0;
    clear_e  = 1'b0;
    clear_m  = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN: begin
          if (bus.mc_op_e) begin
            // Freeze F..E around the op and feed bubbles into M.
            mc_start = 1'b1;
            en_f     = 1'b0;
            en_d     = 1'b0;
            en_e     = 1'b0;
            clear_m  = 1'b1;
            state_d  = MC_WAIT;
          end else if (bus.branch_taken_e) begin
            // Flush wins over load-use: the stalled instruction is discarded.
            clear_d = 1'b1;
            clear_e = 1'b1;
          end else if (load_use) begin
            en_f    = 1'b0;
            en_d    = 1'b0;
            clear_e = 1'b1;
          end
        end
        MC_WAIT: begin
          if (bus.mc_done) begin
            state_d = RUN;
          end else begin
            en_f    = 1'b0;
            en_d    = 1'b0;
            en_e    = 1'b0;
            clear_m = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      stall_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (!en_f && (stall_count_q != {CNT_W{1'b1}})) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.mc_start    = mc_start;
  assign bus.en_f        = en_f;
  assign bus.en_d        = en_d;
  assign bus.en_e        = en_e;
  assign bus.en_m        = en_m;
  assign bus.clear_d     = clear_d;
  assign bus.clear_e     = clear_e;
  assign bus.clear_m     = clear_m;
  assign bus.fwd_a_e     = reset ? FWD_RF : fwd_a;
  assign bus.fwd_b_e     = reset ? FWD_RF : fwd_b;
  assign bus.stall_count = stall_count_q;

endmodule

// File: doc/unidad_riesgos_pipeline.md
Name: unidad_riesgos_pipeline

Overview:
- Hazard and stall controller for the 5-stage pipeline (F, D, E, M, W).
- Drives the enable/clear inputs of the inter-stage enable-clear registers and the 2-bit selects of the E-stage forwarding 3-input muxes.
- Sequences multi-cycle execute operations (iterative multiply/divide) through a start/done handshake.
- Keeps a saturating count of front-end stall cycles.

Parameters:
- REG_ADDR_W, 4, width of register-file addresses.
- CNT_W, 16, width of stall_count.
- ZERO_REG_EN, 0, when 1 register address 0 is never forwarded and never causes a load-use stall.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rs1_d, rs2_d  in  REG_ADDR_W  source registers of the instruction in D.
- rs1_e, rs2_e  in  REG_ADDR_W  source registers of the instruction in E.
- rd_e, rd_m, rd_w  in  REG_ADDR_W  destination registers in E, M, W.
- reg_write_m, reg_write_w  in  1  the instruction in M / W writes rd.
- mem_to_reg_e  in  1  the instruction in E is a load.
- branch_taken_e  in  1  the branch resolved in E is taken.
- mc_op_e  in  1  the instruction in E is a multi-cycle operation.
- mc_done  in  1  multi-cycle unit result valid (single-cycle pulse).
- mc_start  out  1  single-cycle start pulse to the multi-cycle unit.
- en_f, en_d, en_e, en_m  out  1  enables of the PC, F/D, D/E and E/M registers.
- clear_d, clear_e, clear_m  out  1  clears (bubble insert) of the F/D, D/E and E/M registers.
- fwd_a_e, fwd_b_e  out  2  forwarding selects: 00 register file, 01 from W, 10 from M.
- stall_count  out  CNT_W  saturating count of cycles with en_f=0.

Behaviour:
- Reset: state RUN, stall_count=0. While reset is high: all en_*=1, all clear_*=0, mc_start=0, fwd_*=00.
- Clear only takes effect in a register whose enable is 1, so every asserted clear_x must be paired with en_x=1.
- Forwarding (combinational, all states), evaluated per source:
  - 10 if reg_write_m and rd_m==rs_e.
  - else 01 if reg_write_w and rd_w==rs_e.
  - else 00.
  - M has priority over W.
  - When ZERO_REG_EN=1 and rs_e==0, the select is 00.
- FSM has two states, RUN and MC_WAIT.
- RUN with mc_op_e=1:
  - mc_start=1; en_f=en_d=en_e=0; en_m=1, clear_m=1.
  - Next state MC_WAIT.
  - mc_done is ignored in RUN.
- MC_WAIT with mc_done=0: en_f=en_d=en_e=0; en_m=1, clear_m=1; mc_start=0.
- MC_WAIT with mc_done=1: all enables 1, no clears; next state RUN.
  - Minimum op occupancy is 2 cycles: start plus done.
  - A following mc op in E starts a fresh handshake the next cycle.
- RUN with mc_op_e=0, load-use condition: mem_to_reg_e and rd_e equals rs1_d or rs2_d.
  - en_f=en_d=0; en_e=1, clear_e=1 (one-cycle bubble).
- RUN with mc_op_e=0, branch_taken_e=1: en all 1; clear_d=1, clear_e=1.
- Priority: mc handling > branch flush > load-use.
  - A taken branch in the same cycle as a load-use match flushes and does not stall: en_f=1, clear_d=clear_e=1.
  - branch_taken_e is ignored while mc_op_e=1 or in MC_WAIT.
- Default in RUN: all enables 1, no clears.
- stall_count increments on every clock edge where en_f=0 and holds at all ones (no wrap).
- Reset asserted mid MC_WAIT: returns to RUN immediately; a mc_done arriving after reset is ignored.

Decomposition:
- Shared package holds:
  - forwarding-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - FSM state encoding RUN/MC_WAIT.
- One sub-module: selector_adelanto, the combinational per-operand forwarding compare, instantiated twice (for a and b).

Test Plan:
- Forwarding: reg_write_m=1, rd_m=3, reg_write_w=1, rd_w=3, rs1_e=3 -> fwd_a_e=10. Then reg_write_m=0 -> fwd_a_e=01. With ZERO_REG_EN=1, rs1_e=0, rd_m=0 -> 00.
- Load-use: mem_to_reg_e=1, rd_e=5, rs2_d=5 -> exactly one cycle of en_f=en_d=0, clear_e=1; stall_count 0->1.
- Branch flush: branch_taken_e=1 with load-use also true -> clear_d=clear_e=1, en_f=1, stall_count unchanged.
- Multi-cycle op: mc_op_e=1 in RUN -> mc_start=1 for exactly one cycle.
  - Stall holds for 4 cycles with clear_m=1.
  - mc_done on the 5th cycle -> all enables 1, state RUN.
  - stall_count=4.
- Reset mid-op: reset asserted 2 cycles into MC_WAIT, then released; a later mc_done pulse -> no effect, en_* all 1, stall_count=0.
- Saturation: CNT_W=3 with 10 consecutive load-use stalls -> stall_count holds at 7.
